// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the add/subtract/compare stage.
//   alu_op_e : opcode encoding (ADD, SUB, CMP, PASSB)
//   flags_t  : {n, z, c, v} condition flags, n in the MSB
//   occ_e    : output buffer occupancy (EMPTY, ONE, TWO)
//   TAG_W, DATA_W : destination tag width and default datapath width
package alu_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    CMP   = 2'd2,
    PASSB = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_e;

  // SUB and CMP both compute A + ~B + 1.
  function automatic logic op_is_sub(alu_op_e op);
    return (op == SUB) || (op == CMP);
  endfunction

endpackage

// File: rtl/alu_nzcv_calc.sv
// alu_nzcv_calc: combinational flag generation and result selection.
// Optional feature: `define ALU_ADD_STAGE_SAT_EN to saturate ADD/SUB results
// on signed overflow (N/Z follow the saturated value, C and V unchanged).
// Ports:
//   i_a, i_b   operands as presented to the stage (B not inverted)
//   i_op       opcode
//   i_sum      adder sum (A + B, or A + ~B + 1 for SUB/CMP)
//   i_cout     adder carry out of the top bit
//   o_flags    {n, z, c, v}
//   o_result   value to write back (A for CMP, B for PASSB)
module alu_nzcv_calc
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  alu_op_e      i_op,
  input  logic [W-1:0] i_sum,
  input  logic         i_cout,
  output flags_t       o_flags,
  output logic [W-1:0] o_result
);

  logic         w_bp_msb;
  logic         w_v;
  logic [W-1:0] w_val;

  always_comb begin
    // Sign of the B operand actually fed to the adder.
    w_bp_msb = op_is_sub(i_op) ? ~i_b[W-1] : i_b[W-1];
    w_v      = (i_a[W-1] == w_bp_msb) && (i_sum[W-1] != i_a[W-1]);
    w_val    = i_sum;
`ifdef ALU_ADD_STAGE_SAT_EN
    // Overflow direction follows the sign of A: positive A can only overflow upward.
    if (w_v && ((i_op == ADD) || (i_op == SUB))) begin
      w_val = i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    o_result = w_val;
    o_flags  = '{n: w_val[W-1], z: (w_val == '0), c: i_cout, v: w_v};
    case (i_op)
      CMP:     o_result = i_a;
      PASSB: begin
        o_result = i_b;
        o_flags  = '{n: i_b[W-1], z: (i_b == '0), c: 1'b0, v: 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_add_stage.sv
// alu_add_stage: registered add/subtract/compare stage with a 2-entry
// (main + skid) output buffer so in_ready is a register.
// Optional feature: `define ALU_ADD_STAGE_SAT_EN for signed saturation of ADD/SUB.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_op, in_a, in_b, in_tag payload
//   out_valid/out_ready  result handshake; out_result, out_flags {N,Z,C,V},
//                        out_tag, out_wr (0 for CMP)
module alu_add_stage
  import alu_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int OP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wr
);

  alu_op_e          w_op;
  logic             w_cin;
  logic [W-1:0]     w_b_eff;
  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic [W-1:0]     w_res;
  flags_t           w_flags;
  logic             w_wr;
  logic             w_accept;
  logic             w_produce;

  occ_e             r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_main_res,   r_skid_res;
  flags_t           r_main_flags, r_skid_flags;
  logic [TAG_W-1:0] r_main_tag,   r_skid_tag;
  logic             r_main_wr,    r_skid_wr;

  // Carry-in comes straight from the opcode; the adder is a single W+1 bit add.
  always_comb begin
    w_op            = alu_op_e'(in_op);
    w_cin           = op_is_sub(w_op);
    w_b_eff         = w_cin ? ~in_b : in_b;
    {w_cout, w_sum} = {1'b0, in_a} + {1'b0, w_b_eff} + {{W{1'b0}}, w_cin};
    w_wr            = (w_op != CMP);
    w_accept        = in_valid & r_in_ready;
    w_produce       = r_out_valid & out_ready;
  end

  alu_nzcv_calc #(.W(W)) u_nzcv (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_op     (w_op),
    .i_sum    (w_sum),
    .i_cout   (w_cout),
    .o_flags  (w_flags),
    .o_result (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_main_res   <= '0;
      r_main_flags <= '0;
      r_main_tag   <= '0;
      r_main_wr    <= 1'b0;
      r_skid_res   <= '0;
      r_skid_flags <= '0;
      r_skid_tag   <= '0;
      r_skid_wr    <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_res   <= w_res;
            r_main_flags <= w_flags;
            r_main_tag   <= in_tag;
            r_main_wr    <= w_wr;
            r_out_valid  <= 1'b1;
            r_state      <= ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_produce) begin
            // Main is stalled; park the new result behind it.
            r_skid_res   <= w_res;
            r_skid_flags <= w_flags;
            r_skid_tag   <= in_tag;
            r_skid_wr    <= w_wr;
            r_in_ready   <= 1'b0;
            r_state      <= TWO;
          end else if (!w_accept && w_produce) begin
            r_out_valid  <= 1'b0;
            r_state      <= EMPTY;
          end else if (w_accept && w_produce) begin
            r_main_res   <= w_res;
            r_main_flags <= w_flags;
            r_main_tag   <= in_tag;
            r_main_wr    <= w_wr;
          end
        end
        TWO: begin
          if (w_produce) begin
            r_main_res   <= r_skid_res;
            r_main_flags <= r_skid_flags;
            r_main_tag   <= r_skid_tag;
            r_main_wr    <= r_skid_wr;
            r_in_ready   <= 1'b1;
            r_state      <= ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    in_ready   = r_in_ready;
    out_valid  = r_out_valid;
    out_result = r_main_res;
    out_flags  = r_main_flags;
    out_tag    = r_main_tag;
    out_wr     = r_main_wr;
  end

endmodule

// File: tb/tb_alu_add_stage.sv
// Self-checking bench for alu_add_stage: vector table, model-driven random
// stream, backpressure and reset-while-full sequences, all checked through a
// scoreboard queue filled on accept and drained on produce.
module tb_alu_add_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_tag;
  logic        out_wr;

  logic [63:0] exp_res;
  logic [3:0]  exp_flags;
  logic        exp_wr;

  always #5 clk = ~clk;

  alu_add_stage #(.W(64), .OP_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .out_wr     (out_wr)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flags;
    logic [4:0]  tag;
    logic        wr;
    int          cyc;
  } sb_t;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    logic [63:0] res;
    logic [3:0]  fl;
    logic        wr;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vt[13];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   n_acc    = 0;
  bit   chk_lat  = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 65-bit add / unsigned compare, written independently of the adder form.
  function automatic void model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic [3:0] fl, output logic wr);
    logic [64:0] full;
    logic [63:0] s;
    logic        c, v;
    case (op)
      2'd0: begin
        full = {1'b0, a} + {1'b0, b};
        s = full[63:0];
        c = full[64];
        v = (a[63] == b[63]) && (s[63] != a[63]);
      end
      2'd3: begin
        s = b; c = 1'b0; v = 1'b0;
      end
      default: begin
        s = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (s[63] != a[63]);
      end
    endcase
`ifdef ALU_ADD_STAGE_SAT_EN
    if (v && (op == 2'd0 || op == 2'd1))
      s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    res = (op == 2'd2) ? a : s;
    fl  = {s[63], (s == 64'd0), c, v};
    wr  = (op != 2'd2);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          check("result", out_result, mon_e.res);
          check("flags", 64'(out_flags), 64'(mon_e.flags));
          check("tag", 64'(out_tag), 64'(mon_e.tag));
          check("wr", 64'(out_wr), 64'(mon_e.wr));
          if (chk_lat) check("latency", 64'(cycle - mon_e.cyc), 64'd1);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{exp_res, exp_flags, in_tag, exp_wr, cycle});
        n_acc++;
      end
    end
  end

  task automatic set_in(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic [63:0] er, input logic [3:0] ef,
                        input logic ew);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    exp_res = er; exp_flags = ef; exp_wr = ew;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [63:0] er, input logic [3:0] ef,
                      input logic ew);
    set_in(op, a, b, tag, er, ef, ew);
    wait_accept("accept_timeout");
  endtask

  task automatic send_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag);
    logic [63:0] r; logic [3:0] f; logic w;
    model(op, a, b, r, f, w);
    send(op, a, b, tag, r, f, w);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, acc0;
    logic [1:0]  op;
    logic [63:0] a, b;

    vt[0]  = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd0, 4'b0110, 1'b1};
    vt[1]  = '{2'd1, 64'd5, 64'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1};
    vt[2]  = '{2'd2, 64'd7, 64'd7, 5'd2, 64'd7, 4'b0110, 1'b0};
`ifdef ALU_ADD_STAGE_SAT_EN
    vt[3]  = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001, 1'b1};
    vt[7]  = '{2'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd8, 64'h8000_0000_0000_0000, 4'b1011, 1'b1};
    vt[8]  = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9,
               64'h8000_0000_0000_0000, 4'b1011, 1'b1};
`else
    vt[3]  = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'h8000_0000_0000_0000, 4'b1001, 1'b1};
    vt[7]  = '{2'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd8, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1};
    vt[8]  = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9, 64'd0, 4'b0111, 1'b1};
`endif
    vt[4]  = '{2'd0, 64'h1F_0000_0000, 64'h01_0000_0000, 5'd5, 64'h20_0000_0000, 4'b0000, 1'b1};
    vt[5]  = '{2'd3, 64'd123, 64'h8000_0000_0000_0000, 5'd6, 64'h8000_0000_0000_0000, 4'b1000, 1'b1};
    vt[6]  = '{2'd3, 64'd5, 64'd0, 5'd7, 64'd0, 4'b0100, 1'b1};
    vt[9]  = '{2'd1, 64'd0, 64'd0, 5'd10, 64'd0, 4'b0110, 1'b1};
    vt[10] = '{2'd2, 64'd3, 64'd5, 5'd11, 64'd3, 4'b1000, 1'b0};
    vt[11] = '{2'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'd2, 4'b0000, 1'b1};
    vt[12] = '{2'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd13,
               64'h7FFF_FFFF_FFFF_FFFF, 4'b1001, 1'b0};

    // Reset with garbage on the inputs.
    rst = 1'b1; out_ready = 1'b1;
    set_in(2'd1, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 5'h1F, 64'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_wr", 64'(out_wr), 64'd0);
    @(posedge clk); #1;

    // Directed vectors, consumer always ready.
    chk_lat = 1'b1;
    for (int i = 0; i < 13; i++)
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].res, vt[i].fl, vt[i].wr);
    in_valid = 1'b0;
    drain("drain_table");

    // Streaming: 100 back-to-back random ops.
    @(posedge clk); #1;
    c0 = cycle; acc0 = n_acc;
    for (int i = 0; i < 100; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (i % 10 == 0) begin
        a = {27'd0, 5'($urandom), 32'd0} | 64'h1F_0000_0000;
        b = 64'h01_0000_0000;
        op = 2'd0;
      end else if (i % 10 == 5) begin
        b = a;
      end
      send_model(op, a, b, 5'(i));
    end
    in_valid = 1'b0;
    check("stream_cycles", 64'(cycle - c0), 64'd100);
    check("stream_accepts", 64'(n_acc - acc0), 64'd100);
    drain("drain_stream");

    // Backpressure: fill both entries, hold a third request.
    chk_lat = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc0 = n_acc;
    send_model(2'd0, 64'd10, 64'd20, 5'd10);
    send_model(2'd1, 64'd100, 64'd1, 5'd11);
    set_in(2'd0, 64'd40, 64'd2, 5'd12, 64'd42, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_tag", 64'(out_tag), 64'd10);
      check("bp_out_result", out_result, 64'd30);
    end
    check("bp_accepts", 64'(n_acc - acc0), 64'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("bp_third_accept");
    in_valid = 1'b0;
    check("bp_accepts_after", 64'(n_acc - acc0), 64'd3);
    drain("drain_bp");

    // Reset while both entries are occupied.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_model(2'd0, 64'd1, 64'd1, 5'd20);
    send_model(2'd0, 64'd2, 64'd2, 5'd21);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1; chk_lat = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    acc0 = n_acc;
    send(2'd0, 64'd2, 64'd3, 5'd22, 64'd5, 4'b0000, 1'b1);
    in_valid = 1'b0;
    drain("drain_rst2");
    check("rst2_accepts", 64'(n_acc - acc0), 64'd1);
    @(negedge clk);
    check("rst2_idle_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
